// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage controller.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] BUBBLE_PC_DEFAULT = 32'h1bfffffc;
    localparam logic [3:0]  WE_NONE           = 4'b0000;

endpackage

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: takes one instruction from EXE, performs its data SRAM
// access (if any), and hands the writeback result to WB.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | stage empty, ready to accept
// REQ   | one-cycle SRAM request for the latched load/store
// WAIT  | load outstanding, counting down the SRAM read latency
// DONE  | result presented to WB, held until ws_allowin
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int          RD_LATENCY = 1,
    parameter logic [31:0] BUBBLE_PC  = BUBBLE_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        es_valid,
    output logic        ms_allowin,
    input  logic        mem_en,
    input  logic [3:0]  data_sram_we_in,
    input  logic [31:0] rkd_value,
    input  logic [31:0] alu_result,
    input  logic        rf_we_in,
    input  logic [4:0]  rf_waddr_in,
    input  logic        rf_or_mem,
    input  logic [31:0] pc_in,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata,
    output logic        ws_valid,
    input  logic        ws_allowin,
    output logic [31:0] ws_pc,
    output logic        ws_rf_we,
    output logic [4:0]  ws_rf_waddr,
    output logic [31:0] ws_rf_wdata
);

    localparam int            CW       = $clog2(RD_LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(RD_LATENCY - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    we_q;
    logic [31:0]   rkd_q;
    logic [31:0]   alu_q;
    logic [31:0]   pc_q;
    logic [31:0]   wdata_q;
    logic          rf_we_q;
    logic          rf_or_mem_q;
    logic [4:0]    waddr_q;
    logic          accept;

    assign ms_allowin = (state == IDLE) || ((state == DONE) && ws_allowin);
    // Bubble PCs are dropped without occupying the stage.
    assign accept     = es_valid && ms_allowin && (pc_in != BUBBLE_PC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            we_q        <= WE_NONE;
            rkd_q       <= '0;
            alu_q       <= '0;
            pc_q        <= '0;
            wdata_q     <= '0;
            rf_we_q     <= 1'b0;
            rf_or_mem_q <= 1'b0;
            waddr_q     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q        <= data_sram_we_in;
                rkd_q       <= rkd_value;
                alu_q       <= alu_result;
                pc_q        <= pc_in;
                wdata_q     <= alu_result;
                rf_we_q     <= rf_we_in;
                rf_or_mem_q <= rf_or_mem;
                waddr_q     <= rf_waddr_in;
            end
            if (state == REQ) begin
                cnt <= CNT_INIT;
            end else if (state == WAIT) begin
                if (cnt == '0) begin
                    wdata_q <= rf_or_mem_q ? data_sram_rdata : alu_q;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        data_sram_en    = 1'b0;
        data_sram_we    = WE_NONE;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        ws_valid        = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = mem_en ? REQ : DONE;
            end
            REQ: begin
                data_sram_en    = 1'b1;
                data_sram_we    = we_q;
                data_sram_addr  = alu_q;
                data_sram_wdata = rkd_q;
                state_nxt       = (we_q != WE_NONE) ? DONE : WAIT;
            end
            WAIT: begin
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                ws_valid = 1'b1;
                // A same-cycle accept replaces the retiring result with no bubble.
                if (ws_allowin) begin
                    if (accept) state_nxt = mem_en ? REQ : DONE;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ws_pc       = pc_q;
    assign ws_rf_we    = ws_valid && rf_we_q;
    assign ws_rf_waddr = waddr_q;
    assign ws_rf_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: two instances (read latency 1 and 3) checked every
// cycle against a timing/transaction model, plus directed literal checks.
module tb_mem_stage_ctrl;

    localparam logic [31:0] BUBBLE = 32'h1bfffffc;

    logic        clk = 1'b0;
    logic        rst;
    logic        es_valid;
    logic        mem_en;
    logic [3:0]  we_in;
    logic [31:0] rkd;
    logic [31:0] alu;
    logic        rf_we_in;
    logic [4:0]  waddr_in;
    logic        rf_or_mem;
    logic [31:0] pc_in;
    logic        ws_allowin;

    logic        ms_allowin      [2];
    logic        sram_en         [2];
    logic [3:0]  sram_we         [2];
    logic [31:0] sram_addr       [2];
    logic [31:0] sram_wdata      [2];
    logic [31:0] sram_rdata      [2];
    logic        ws_valid        [2];
    logic [31:0] ws_pc           [2];
    logic        ws_rf_we        [2];
    logic [4:0]  ws_rf_waddr     [2];
    logic [31:0] ws_rf_wdata     [2];

    int tests = 0;
    int fails = 0;
    int delivered [2];

    always #5 clk = ~clk;

    mem_stage_ctrl #(.RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .es_valid(es_valid), .ms_allowin(ms_allowin[0]),
        .mem_en(mem_en), .data_sram_we_in(we_in), .rkd_value(rkd), .alu_result(alu),
        .rf_we_in(rf_we_in), .rf_waddr_in(waddr_in), .rf_or_mem(rf_or_mem), .pc_in(pc_in),
        .data_sram_en(sram_en[0]), .data_sram_we(sram_we[0]), .data_sram_addr(sram_addr[0]),
        .data_sram_wdata(sram_wdata[0]), .data_sram_rdata(sram_rdata[0]),
        .ws_valid(ws_valid[0]), .ws_allowin(ws_allowin), .ws_pc(ws_pc[0]),
        .ws_rf_we(ws_rf_we[0]), .ws_rf_waddr(ws_rf_waddr[0]), .ws_rf_wdata(ws_rf_wdata[0])
    );

    mem_stage_ctrl #(.RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .es_valid(es_valid), .ms_allowin(ms_allowin[1]),
        .mem_en(mem_en), .data_sram_we_in(we_in), .rkd_value(rkd), .alu_result(alu),
        .rf_we_in(rf_we_in), .rf_waddr_in(waddr_in), .rf_or_mem(rf_or_mem), .pc_in(pc_in),
        .data_sram_en(sram_en[1]), .data_sram_we(sram_we[1]), .data_sram_addr(sram_addr[1]),
        .data_sram_wdata(sram_wdata[1]), .data_sram_rdata(sram_rdata[1]),
        .ws_valid(ws_valid[1]), .ws_allowin(ws_allowin), .ws_pc(ws_pc[1]),
        .ws_rf_we(ws_rf_we[1]), .ws_rf_waddr(ws_rf_waddr[1]), .ws_rf_wdata(ws_rf_wdata[1])
    );

    function automatic int rdl(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // SRAM contents as a pure function of address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h100) return 32'hdeadbeef;
        return (a * 32'h9e3779b1) ^ 32'h5bd1e995;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + SRAM responder + compare ----------------
    int          cyc = 0;
    bit          occ    [2];
    int          acc_c  [2];
    int          lat    [2];
    logic        m_mem  [2];
    logic [3:0]  m_we   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_rkd  [2];
    logic [31:0] m_pc   [2];
    logic        m_rfwe [2];
    logic [4:0]  m_wa   [2];
    logic [31:0] m_wd   [2];
    bit          pend_v    [2];
    int          pend_due  [2];
    logic [31:0] pend_data [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            occ[k] = 0; pend_v[k] = 0; delivered[k] = 0; sram_rdata[k] = '0;
        end
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                bit vexp, aexp, eexp;
                sram_rdata[k] = (pend_v[k] && pend_due[k] == cyc) ? pend_data[k] : $urandom;
                vexp = occ[k] && (cyc >= acc_c[k] + lat[k]);
                aexp = !occ[k] || (vexp && ws_allowin);
                eexp = occ[k] && m_mem[k] && (cyc == acc_c[k] + 1);
                chk($sformatf("m%0d ms_allowin", k), 32'(ms_allowin[k]), 32'(aexp));
                chk($sformatf("m%0d ws_valid", k), 32'(ws_valid[k]), 32'(vexp));
                chk($sformatf("m%0d sram_en", k), 32'(sram_en[k]), 32'(eexp));
                if (eexp) begin
                    chk($sformatf("m%0d sram_we", k), 32'(sram_we[k]), 32'(m_we[k]));
                    chk($sformatf("m%0d sram_addr", k), sram_addr[k], m_addr[k]);
                    chk($sformatf("m%0d sram_wdata", k), sram_wdata[k], m_rkd[k]);
                end else begin
                    chk($sformatf("m%0d sram_we idle", k), 32'(sram_we[k]), 32'h0);
                end
                if (vexp) begin
                    chk($sformatf("m%0d ws_pc", k), ws_pc[k], m_pc[k]);
                    chk($sformatf("m%0d ws_rf_we", k), 32'(ws_rf_we[k]), 32'(m_rfwe[k]));
                    chk($sformatf("m%0d ws_rf_waddr", k), 32'(ws_rf_waddr[k]), 32'(m_wa[k]));
                    chk($sformatf("m%0d ws_rf_wdata", k), ws_rf_wdata[k], m_wd[k]);
                end else begin
                    chk($sformatf("m%0d ws_rf_we idle", k), 32'(ws_rf_we[k]), 32'h0);
                end
                if (sram_en[k] === 1'b1 && sram_we[k] === 4'h0) begin
                    pend_v[k]    = 1;
                    pend_due[k]  = cyc + rdl(k);
                    pend_data[k] = mem_f(sram_addr[k]);
                end
                if (rst) begin
                    occ[k] = 0;
                end else begin
                    if (vexp && ws_allowin) begin
                        occ[k] = 0;
                        delivered[k]++;
                    end
                    if (es_valid && aexp && pc_in != BUBBLE) begin
                        occ[k]    = 1;
                        acc_c[k]  = cyc;
                        m_mem[k]  = mem_en;
                        m_we[k]   = we_in;
                        m_addr[k] = alu;
                        m_rkd[k]  = rkd;
                        m_pc[k]   = pc_in;
                        m_rfwe[k] = rf_we_in;
                        m_wa[k]   = waddr_in;
                        if (!mem_en)           lat[k] = 1;
                        else if (we_in != 4'h0) lat[k] = 2;
                        else                    lat[k] = rdl(k) + 2;
                        m_wd[k] = (mem_en && we_in == 4'h0 && rf_or_mem) ? mem_f(alu) : alu;
                    end
                end
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [3:0] we, input logic [31:0] a,
                         input logic [31:0] r, input logic rfw, input logic [4:0] wa,
                         input logic rom, input logic [31:0] pc);
        es_valid = 1'b1; mem_en = m; we_in = we; alu = a; rkd = r;
        rf_we_in = rfw; waddr_in = wa; rf_or_mem = rom; pc_in = pc;
    endtask

    task automatic rand_inputs();
        int kind;
        kind       = int'($urandom_range(0, 2));
        es_valid   = ($urandom_range(0, 9) < 7);
        mem_en     = (kind != 0);
        we_in      = (kind == 2) ? 4'($urandom_range(1, 15)) : 4'h0;
        rkd        = $urandom;
        alu        = $urandom;
        rf_we_in   = (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        waddr_in   = 5'($urandom);
        rf_or_mem  = (kind == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        pc_in      = ($urandom_range(0, 15) == 0) ? BUBBLE : $urandom;
        ws_allowin = ($urandom_range(0, 9) < 7);
        rst        = ($urandom_range(0, 299) == 0);
    endtask

    initial begin
        rst = 1'b1; es_valid = 0; mem_en = 0; we_in = 0; rkd = 0; alu = 0;
        rf_we_in = 0; waddr_in = 0; rf_or_mem = 0; pc_in = 0; ws_allowin = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset ws_valid", 32'(ws_valid[k]), 32'h0);
            chk("reset sram_en", 32'(sram_en[k]), 32'h0);
            chk("reset ms_allowin", 32'(ms_allowin[k]), 32'h1);
            chk("reset ws_rf_wdata", ws_rf_wdata[k], 32'h0);
        end

        // ALU op
        step(); drive(0, 4'h0, 32'h1234, 32'h0, 1, 5'd5, 0, 32'h1c000000);
        step(); es_valid = 0;
        @(negedge clk);
        chk("alu ws_valid", 32'(ws_valid[0]), 32'h1);
        chk("alu wdata", ws_rf_wdata[0], 32'h1234);
        chk("alu waddr", 32'(ws_rf_waddr[0]), 32'd5);
        chk("alu sram_en", 32'(sram_en[0]), 32'h0);

        // Load from 0x100 on both latencies
        step(); drive(1, 4'h0, 32'h100, 32'h0, 1, 5'd7, 1, 32'h1c000004);
        step(); es_valid = 0;
        @(negedge clk);
        chk("ld en lat1", 32'(sram_en[0]), 32'h1);
        chk("ld en lat3", 32'(sram_en[1]), 32'h1);
        chk("ld addr", sram_addr[0], 32'h100);
        step(); @(negedge clk);
        chk("ld lat1 early", 32'(ws_valid[0]), 32'h0);
        step(); @(negedge clk);
        chk("ld lat1 valid", 32'(ws_valid[0]), 32'h1);
        chk("ld lat1 data", ws_rf_wdata[0], 32'hdeadbeef);
        step(); @(negedge clk);
        chk("ld lat3 early", 32'(ws_valid[1]), 32'h0);
        step(); @(negedge clk);
        chk("ld lat3 valid", 32'(ws_valid[1]), 32'h1);
        chk("ld lat3 data", ws_rf_wdata[1], 32'hdeadbeef);

        // Store
        step(); drive(1, 4'hf, 32'h200, 32'hcafe, 0, 5'd0, 0, 32'h1c000008);
        @(negedge clk);
        chk("st allowin idle", 32'(ms_allowin[0]), 32'h1);
        step(); es_valid = 0;
        @(negedge clk);
        chk("st en", 32'(sram_en[0]), 32'h1);
        chk("st we", 32'(sram_we[0]), 32'hf);
        chk("st addr", sram_addr[0], 32'h200);
        chk("st wdata", sram_wdata[0], 32'hcafe);
        chk("st allowin req", 32'(ms_allowin[0]), 32'h0);
        step(); @(negedge clk);
        chk("st en done", 32'(sram_en[0]), 32'h0);
        chk("st ws_valid", 32'(ws_valid[0]), 32'h1);
        chk("st ws_rf_we", 32'(ws_rf_we[0]), 32'h0);
        chk("st allowin done", 32'(ms_allowin[0]), 32'h1);

        // Bubble PC
        step(); drive(1, 4'h0, 32'h300, 32'h0, 1, 5'd3, 1, BUBBLE);
        step(); es_valid = 0; pc_in = 0;
        @(negedge clk);
        chk("bubble ws_valid", 32'(ws_valid[0]), 32'h0);
        chk("bubble en", 32'(sram_en[0]), 32'h0);
        chk("bubble allowin", 32'(ms_allowin[0]), 32'h1);

        // Back-to-back ALU ops with a WB stall
        step(); drive(0, 4'h0, 32'ha1, 32'h0, 1, 5'd1, 0, 32'h1c000010);
        step(); drive(0, 4'h0, 32'ha2, 32'h0, 1, 5'd2, 0, 32'h1c000014); ws_allowin = 0;
        @(negedge clk);
        chk("stall c1 data", ws_rf_wdata[0], 32'ha1);
        chk("stall c1 allowin", 32'(ms_allowin[0]), 32'h0);
        step(); @(negedge clk);
        chk("stall c2 data", ws_rf_wdata[0], 32'ha1);
        chk("stall c2 allowin", 32'(ms_allowin[0]), 32'h0);
        step(); ws_allowin = 1;
        @(negedge clk);
        chk("stall c3 data", ws_rf_wdata[0], 32'ha1);
        chk("stall c3 allowin", 32'(ms_allowin[0]), 32'h1);
        step(); drive(0, 4'h0, 32'ha3, 32'h0, 1, 5'd3, 0, 32'h1c000018);
        @(negedge clk);
        chk("stall c4 data", ws_rf_wdata[0], 32'ha2);
        step(); es_valid = 0;
        @(negedge clk);
        chk("stall c5 data", ws_rf_wdata[0], 32'ha3);
        chk("stall c5 waddr", 32'(ws_rf_waddr[0]), 32'd3);

        // Reset while the latency-3 load waits
        step(); drive(1, 4'h0, 32'h400, 32'h0, 1, 5'd9, 1, 32'h1c00001c);
        step(); es_valid = 0;
        step(); rst = 1;
        step(); rst = 0;
        @(negedge clk);
        chk("rstwait ws_valid", 32'(ws_valid[1]), 32'h0);
        chk("rstwait allowin", 32'(ms_allowin[1]), 32'h1);
        step(); step(); @(negedge clk);
        chk("rstwait late rdata", 32'(ws_valid[1]), 32'h0);

        // Random traffic
        repeat (3000) begin
            step();
            rand_inputs();
        end
        step();
        rst = 0; es_valid = 0; ws_allowin = 1;
        repeat (10) step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (delivered[k] < 100) begin
                fails++;
                $display("FAIL delivered m%0d: got %0d expected at least 100", k, delivered[k]);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
